// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-ported data RAM between the cpu data port (master 0) and a
// DMA/debug loader (master 1). One request is routed to the RAM per cycle. Contention is
// settled round-robin, and a locked owner may keep the RAM for up to MAX_HOLD consecutive
// grants while the other master waits. Read data comes back one cycle after the grant and
// is tagged to the master that issued the read.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-low reset
//   i_mX_req/we/lock      master X request, write (1) / read (0), keep-ownership hint
//   i_mX_addr/sel/wdata   master X address, byte selects, write data
//   o_mX_gnt              master X accepted this cycle (combinational)
//   o_m0_stall            master 0 requesting but not granted
//   o_mX_rvalid/rdata     master X read data return (valid one cycle after grant)
//   o_ram_*               RAM enable, write enable, address, byte select, write data
//   i_ram_data            RAM read data, valid one cycle after a read enable
module ram_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic              i_m0_lock,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [SEL_W-1:0]  i_m0_sel,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic              o_m0_gnt,
  output logic              o_m0_stall,
  output logic              o_m0_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic              i_m1_lock,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [SEL_W-1:0]  i_m1_sel,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_ram_enabler,
  output logic              o_ram_write_enabler,
  output logic [ADDR_W-1:0] o_ram_addr_output,
  output logic [SEL_W-1:0]  o_ram_select_output,
  output logic [DATA_W-1:0] o_ram_data_output,
  input  logic [DATA_W-1:0] i_ram_data
);

  localparam logic [3:0] MaxHold = 4'(MAX_HOLD);

  logic       r_last_winner;  // 0: m0, 1: m1
  logic       r_owner_valid;  // last winner asked to keep the RAM
  logic [3:0] r_hold_cnt;
  logic       r_rd_valid;
  logic       r_rd_tag;

  logic       w_last_winner_d;
  logic       w_owner_valid_d;
  logic [3:0] w_hold_cnt_d;
  logic       w_rd_valid_d;
  logic       w_rd_tag_d;

  logic       w_gnt_any;
  logic       w_winner;
  logic       w_we;
  logic       w_lock;

  // Arbitration from registered state; nothing is granted while reset is asserted.
  always_comb begin
    w_gnt_any = 1'b0;
    w_winner  = 1'b0;
    if (i_rst) begin
      unique case ({i_m1_req, i_m0_req})
        2'b01: begin
          w_gnt_any = 1'b1;
          w_winner  = 1'b0;
        end
        2'b10: begin
          w_gnt_any = 1'b1;
          w_winner  = 1'b1;
        end
        2'b11: begin
          w_gnt_any = 1'b1;
          // A saturated hold count forces the lock holder to give way.
          if (r_owner_valid && (r_hold_cnt < MaxHold)) begin
            w_winner = r_last_winner;
          end else begin
            w_winner = ~r_last_winner;
          end
        end
        default: begin
          w_gnt_any = 1'b0;
          w_winner  = 1'b0;
        end
      endcase
    end
  end

  // Request mux: m0 fields are presented whenever m1 is not the winner.
  assign w_we   = w_winner ? i_m1_we : i_m0_we;
  assign w_lock = w_winner ? i_m1_lock : i_m0_lock;

  assign o_ram_enabler       = w_gnt_any;
  assign o_ram_write_enabler = w_gnt_any & w_we;
  assign o_ram_addr_output   = w_winner ? i_m1_addr : i_m0_addr;
  assign o_ram_select_output = w_winner ? i_m1_sel : i_m0_sel;
  assign o_ram_data_output   = w_winner ? i_m1_wdata : i_m0_wdata;

  assign o_m0_gnt   = w_gnt_any & ~w_winner;
  assign o_m1_gnt   = w_gnt_any & w_winner;
  assign o_m0_stall = i_m0_req & ~o_m0_gnt;

  assign o_m0_rvalid = r_rd_valid & ~r_rd_tag;
  assign o_m1_rvalid = r_rd_valid & r_rd_tag;
  assign o_m0_rdata  = i_ram_data;
  assign o_m1_rdata  = i_ram_data;

  always_comb begin
    w_last_winner_d = r_last_winner;
    w_owner_valid_d = 1'b0;
    w_hold_cnt_d    = 4'd0;
    w_rd_valid_d    = 1'b0;
    w_rd_tag_d      = r_rd_tag;
    if (w_gnt_any) begin
      w_last_winner_d = w_winner;
      if (w_lock) begin
        w_owner_valid_d = 1'b1;
        // Keep counting only while the same owner stays locked; saturate, never wrap.
        if (r_owner_valid && (w_winner == r_last_winner)) begin
          w_hold_cnt_d = (r_hold_cnt >= MaxHold) ? r_hold_cnt : r_hold_cnt + 4'd1;
        end else begin
          w_hold_cnt_d = 4'd1;
        end
      end
      if (!w_we) begin
        w_rd_valid_d = 1'b1;
        w_rd_tag_d   = w_winner;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_last_winner <= 1'b1;
      r_owner_valid <= 1'b0;
      r_hold_cnt    <= 4'd0;
      r_rd_valid    <= 1'b0;
      r_rd_tag      <= 1'b0;
    end else begin
      r_last_winner <= w_last_winner_d;
      r_owner_valid <= w_owner_valid_d;
      r_hold_cnt    <= w_hold_cnt_d;
      r_rd_valid    <= w_rd_valid_d;
      r_rd_tag      <= w_rd_tag_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios followed by randomized traffic, checked against a
// cycle-level reference of the arbitration rules and a reference copy of the RAM contents.
module tb_ram_arbiter;

  localparam int MaxHold = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req   [2];
  logic        we    [2];
  logic        lock  [2];
  logic [31:0] addr  [2];
  logic [3:0]  sel   [2];
  logic [31:0] wdata [2];

  logic        m0_gnt, m0_stall, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [3:0]  ram_sel;
  logic [31:0] ram_data = '0;

  always #5 clk = ~clk;

  ram_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .SEL_W   (4),
    .MAX_HOLD(MaxHold)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_m0_req           (req[0]),
    .i_m0_we            (we[0]),
    .i_m0_lock          (lock[0]),
    .i_m0_addr          (addr[0]),
    .i_m0_sel           (sel[0]),
    .i_m0_wdata         (wdata[0]),
    .o_m0_gnt           (m0_gnt),
    .o_m0_stall         (m0_stall),
    .o_m0_rvalid        (m0_rvalid),
    .o_m0_rdata         (m0_rdata),
    .i_m1_req           (req[1]),
    .i_m1_we            (we[1]),
    .i_m1_lock          (lock[1]),
    .i_m1_addr          (addr[1]),
    .i_m1_sel           (sel[1]),
    .i_m1_wdata         (wdata[1]),
    .o_m1_gnt           (m1_gnt),
    .o_m1_rvalid        (m1_rvalid),
    .o_m1_rdata         (m1_rdata),
    .o_ram_enabler      (ram_en),
    .o_ram_write_enabler(ram_we),
    .o_ram_addr_output  (ram_addr),
    .o_ram_select_output(ram_sel),
    .o_ram_data_output  (ram_wdata),
    .i_ram_data         (ram_data)
  );

  // RAM attached to the DUT's RAM port, one-cycle read latency, byte-selected writes.
  logic [31:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_sel[b]) ram_mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end else begin
        ram_data <= ram_mem[ram_addr[7:0]];
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [256];
  int          last_w;      // master that won most recently
  bit          owner_locked;
  int          streak;      // consecutive locked grants of the current owner
  bit          exp_rv;
  int          exp_tag;
  logic [31:0] exp_data;
  bit          granted [2]; // master's request consumed at the last edge
  bit          seen_gnt1;
  bit          seen_gnt0;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int ref_winner();
    if (req[0] && !req[1]) return 0;
    if (req[1] && !req[0]) return 1;
    if (!req[0] && !req[1]) return -1;
    if (owner_locked && streak < MaxHold) return last_w;
    return 1 - last_w;
  endfunction

  // One clock cycle: rc is reset during the cycle, re is reset as sampled at the closing edge.
  task automatic step(input bit rc, input bit re);
    int w;
    int we_edge;
    rst = rc;
    #2;
    w = rc ? ref_winner() : -1;
    chk("m0_gnt", m0_gnt, w == 0);
    chk("m1_gnt", m1_gnt, w == 1);
    chk("m0_stall", m0_stall, req[0] && w != 0);
    chk("ram_en", ram_en, w >= 0);
    chk("ram_we", ram_we, w >= 0 && we[w]);
    if (w >= 0) begin
      chk("ram_addr", ram_addr, addr[w]);
      chk("ram_sel", ram_sel, sel[w]);
      chk("ram_wdata", ram_wdata, wdata[w]);
    end
    chk("m0_rvalid", m0_rvalid, exp_rv && exp_tag == 0);
    chk("m1_rvalid", m1_rvalid, exp_rv && exp_tag == 1);
    if (exp_rv) chk("rdata", (exp_tag == 1) ? m1_rdata : m0_rdata, exp_data);
    seen_gnt0 = m0_gnt;
    seen_gnt1 = m1_gnt;
    rst = re;
    we_edge = re ? ref_winner() : -1;
    @(posedge clk);
    granted[0] = (we_edge == 0);
    granted[1] = (we_edge == 1);
    if (!re) begin
      last_w = 1; owner_locked = 0; streak = 0; exp_rv = 0;
    end else if (we_edge < 0) begin
      owner_locked = 0; streak = 0; exp_rv = 0;
    end else begin
      exp_rv = !we[we_edge];
      exp_tag = we_edge;
      exp_data = ref_mem[addr[we_edge][7:0]];
      if (we[we_edge]) begin
        for (int b = 0; b < 4; b++) begin
          if (sel[we_edge][b]) ref_mem[addr[we_edge][7:0]][8*b +: 8] = wdata[we_edge][8*b +: 8];
        end
      end
      if (lock[we_edge]) begin
        if (owner_locked && we_edge == last_w) streak = (streak < MaxHold) ? streak + 1 : streak;
        else streak = 1;
        owner_locked = 1;
      end else begin
        owner_locked = 0;
        streak = 0;
      end
      last_w = we_edge;
    end
    #1;
  endtask

  task automatic set_m(input int m, input bit r, input bit w_, input bit l, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    req[m] = r; we[m] = w_; lock[m] = l; addr[m] = a; sel[m] = s; wdata[m] = d;
  endtask

  initial begin
    int m1_run;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    last_w = 1; owner_locked = 0; streak = 0; exp_rv = 0; exp_tag = 0; exp_data = '0;
    granted[0] = 0; granted[1] = 0;

    // Reset holds off grants even with both masters requesting.
    set_m(0, 1, 0, 0, 32'h4, 4'hf, 32'h0);
    set_m(1, 1, 0, 0, 32'h8, 4'hf, 32'h0);
    step(0, 0);
    step(0, 0);
    // First cycle out of reset: m0 wins the tie.
    step(1, 1);
    chk("first_tie_m0", seen_gnt0, 1);

    // Lone read by m1 at 0x10, then its return.
    set_m(0, 0, 0, 0, 32'h0, 4'hf, 32'h0);
    set_m(1, 1, 0, 0, 32'h10, 4'hf, 32'h0);
    step(1, 1);
    set_m(1, 0, 0, 0, 32'h0, 4'hf, 32'h0);
    step(1, 1);

    // Write pass-through, then read back the partial write.
    set_m(0, 1, 1, 0, 32'h20, 4'b0011, 32'hDEADBEEF);
    step(1, 1);
    set_m(0, 0, 0, 0, 32'h0, 4'hf, 32'h0);
    step(1, 1);
    set_m(1, 1, 0, 0, 32'h20, 4'hf, 32'h0);
    step(1, 1);
    set_m(1, 0, 0, 0, 32'h0, 4'hf, 32'h0);
    step(1, 1);

    // Round-robin with continuous contention.
    set_m(0, 1, 0, 0, 32'h20, 4'hf, 32'h0);
    set_m(1, 1, 0, 0, 32'h10, 4'hf, 32'h0);
    for (int i = 0; i < 4; i++) step(1, 1);

    // Lock bound: m0 wins once, then locked m1 holds for MaxHold grants before release.
    set_m(1, 0, 0, 0, 32'h10, 4'hf, 32'h0);
    step(1, 1);
    set_m(1, 1, 0, 1, 32'h10, 4'hf, 32'h0);
    m1_run = 0;
    for (int i = 0; i < MaxHold; i++) begin
      step(1, 1);
      m1_run += int'(seen_gnt1);
    end
    chk("lock_run_len", m1_run, MaxHold);
    step(1, 1);
    chk("lock_release_m0", seen_gnt0, 1);

    // Reset lands on the edge that would launch m0's read return.
    set_m(1, 0, 0, 0, 32'h0, 4'hf, 32'h0);
    set_m(0, 1, 0, 0, 32'h20, 4'hf, 32'h0);
    step(1, 1);
    step(1, 0);
    set_m(0, 0, 0, 0, 32'h0, 4'hf, 32'h0);
    step(1, 1);
    set_m(0, 1, 0, 0, 32'h4, 4'hf, 32'h0);
    set_m(1, 1, 0, 1, 32'h8, 4'hf, 32'h0);
    step(1, 1);
    chk("post_reset_tie_m0", seen_gnt0, 1);

    // Random traffic; ungranted requests stay stable until accepted.
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (granted[m] || !req[m]) begin
          set_m(m, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0, 32'($urandom_range(0, 63)), 4'($urandom),
                $urandom);
        end
      end
      if (i % 150 == 149) step(1, 0);
      else step(1, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-port arbiter that shares the single data RAM between the mips core's data port (master 0) and a DMA/debug loader (master 1). It sits between both masters and the ram instance, and muxes one master's request onto the RAM each cycle. It uses round-robin on contention, with an optional bounded lock for bursts. It returns read data with the RAM's 1-cycle read latency, tagged to the requesting master.

Parameters:
ADDR_W, 32, address width of both masters and RAM
DATA_W, 32, data width
SEL_W, 4, byte-select width (DATA_W/8)
MAX_HOLD, 4, max consecutive locked grants to one master while the other is requesting (1..15)

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  synchronous reset, active-low
m0_req  input  1  master 0 (cpu) access request
m0_we  input  1  master 0 write (1) / read (0)
m0_lock  input  1  master 0 requests to retain ownership next cycle
m0_addr  input  ADDR_W  master 0 address
m0_sel  input  SEL_W  master 0 byte selects
m0_wdata  input  DATA_W  master 0 write data
m0_gnt  output  1  master 0 request accepted this cycle (combinational)
m0_stall  output  1  m0_req & ~m0_gnt; drives cpu pipeline stall
m0_rvalid  output  1  master 0 read data valid (registered)
m0_rdata  output  DATA_W  master 0 read data
m1_req, m1_we, m1_lock, m1_addr, m1_sel, m1_wdata  input  as m0  master 1 (dma) request
m1_gnt, m1_rvalid, m1_rdata  output  as m0  master 1 responses
ram_enabler  output  1  RAM enable
ram_write_enabler  output  1  RAM write enable
ram_addr_output  output  ADDR_W  RAM address
ram_select_output  output  SEL_W  RAM byte select
ram_data_output  output  DATA_W  RAM write data
ram_data  input  DATA_W  RAM read data, valid 1 cycle after a read enable

Behaviour:
- Reset (rst=0 at edge): last_winner<=1 (m0 wins the first tie), owner_valid<=0, hold_cnt<=0, m0_rvalid/m1_rvalid<=0, rd_tag<=0. While rst=0: m0_gnt=m1_gnt=0, ram_enabler=0, ram_write_enabler=0. Mux outputs are driven from m0 fields. m0_stall=m0_req.
- Arbitration, per cycle, combinational from registered state:
  - Only one master requests: grant it.
  - Both request, owner_valid=1 and hold_cnt<MAX_HOLD: grant the owner.
  - Both request otherwise: grant ~last_winner.
  - Neither requests: no grant; ram_enabler=0.
- Mux: on a grant, ram_* = winner's we/addr/sel/wdata and ram_enabler=1. ram_write_enabler = winner_we.
- State update on a grant:
  - last_winner <= winner.
  - owner_valid <= winner_lock.
  - hold_cnt <= (winner==previous owner && owner_valid) ? hold_cnt+1 : 1.
  - hold_cnt saturates at MAX_HOLD.
- No grant or lock deasserted: owner_valid<=0 and hold_cnt<=0.
- Lock only matters under contention. A lone locked requester is granted indefinitely; hold_cnt saturates and does not wrap.
- Lock forced release: when hold_cnt==MAX_HOLD and the other master requests, the other master wins. That win clears the previous owner's lock.
- Read return: a granted read sets rvalid_tag<=winner and the matching mX_rvalid<=1 for exactly one cycle. mX_rdata = ram_data, passthrough, valid only while mX_rvalid=1.
  - Granted writes produce no rvalid.
  - Back-to-back reads give one rvalid per cycle, in grant order.
- Simultaneous read return and new grant: independent. A return to m0 and a new grant to m1 in the same cycle are both legal.
- Ungranted masters must hold their request fields stable until granted. The arbiter does not register requests.
- Reset mid-operation: a pending rvalid is dropped. Lock and hold state are cleared. The in-flight RAM read result is ignored.
- Latency: grant is 0 cycles after req. Read data is 1 cycle after grant.

Test Plan:
- Reset: rst=0 with m0_req=m1_req=1 -> all gnt=0, ram_enabler=0, rvalid=0. First cycle after rst=1 -> m0_gnt=1.
- Lone read: m1 read addr 0x10 -> m1_gnt same cycle, ram_addr_output=0x10, ram_write_enabler=0. Next cycle m1_rvalid=1 with m1_rdata=ram_data; m0_rvalid=0.
- Round-robin: both request reads continuously, no lock -> grants alternate m0,m1,m0,m1. m0_stall=1 on every m1 cycle.
- Lock bound: m1_lock=1, MAX_HOLD=4, both request -> m1 granted 4 consecutive cycles, then m0 granted on the 5th.
- Write pass-through: m0 write addr 0x20, sel 4'b0011, data 0xDEADBEEF -> ram_write_enabler=1 and all ram fields match. No rvalid follows.
- Reset mid-read: grant m0 read, rst=0 next edge -> m0_rvalid stays 0, hold_cnt=0.
